// File: rtl/muldiv_sequencer.sv
// Iterative RV64M multiply/divide engine: 1 bit per cycle, stalls execute while busy,
// resolves divide-by-zero and signed overflow without iterating.
module muldiv_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  input  logic [2:0]      i_req_op,
  input  logic            i_req_word,
  input  logic [XLEN-1:0] i_req_a,
  input  logic [XLEN-1:0] i_req_b,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_resp_valid,
  output logic [XLEN-1:0] o_resp_data
);
  // state | meaning
  // IDLE  | waiting for an op from execute
  // BUSY  | iterating, one shift-add / restoring-subtract step per cycle
  // DONE  | result valid for one cycle, pipeline released
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_REM  = 3'd3;
  localparam logic [2:0] OP_REMU = 3'd4;

  state_t r_state, w_state_next;

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_x, r_y, r_acc, r_resp_data;
  logic            r_is_div, r_is_rem, r_word, r_sign_q, r_sign_r, r_resp_valid;

  logic            w_accept, w_is_div, w_is_rem, w_signed, w_sa, w_sb;
  logic            w_b_zero, w_ovf, w_special, w_qbit;
  logic [XLEN-1:0] w_a_n, w_b_n, w_min_n, w_mag_a, w_mag_b, w_special_res;
  logic [XLEN-1:0] w_rem_next, w_quot_next, w_prod_next, w_raw, w_final;
  logic [XLEN:0]   w_rem_sh, w_diff;

  function automatic logic [XLEN-1:0] fit_word(input logic [XLEN-1:0] v, input logic word);
    return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Operand normalisation: word ops are sign- or zero-extended so that all
  // special-case detection and magnitude math can run at full width.
  always_comb begin
    w_is_div = (i_req_op >= OP_DIV) && (i_req_op <= OP_REMU);
    w_is_rem = (i_req_op == OP_REM) || (i_req_op == OP_REMU);
    w_signed = (i_req_op == OP_DIV) || (i_req_op == OP_REM);
    w_a_n    = i_req_word ? (w_signed ? fit_word(i_req_a, 1'b1)
                                      : {{(XLEN-32){1'b0}}, i_req_a[31:0]}) : i_req_a;
    w_b_n    = i_req_word ? (w_signed ? fit_word(i_req_b, 1'b1)
                                      : {{(XLEN-32){1'b0}}, i_req_b[31:0]}) : i_req_b;
    w_sa     = w_signed & (i_req_word ? i_req_a[31] : i_req_a[XLEN-1]);
    w_sb     = w_signed & (i_req_word ? i_req_b[31] : i_req_b[XLEN-1]);
    w_min_n  = i_req_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    w_b_zero = (w_b_n == '0);
    w_ovf    = w_signed & (w_a_n == w_min_n) & (w_b_n == '1);
    w_special = w_is_div & (w_b_zero | w_ovf);
    w_special_res = fit_word(w_b_zero ? (w_is_rem ? w_a_n : '1)
                                      : (w_is_rem ? '0 : w_a_n), i_req_word);
    w_mag_a  = w_sa ? -w_a_n : w_a_n;
    w_mag_b  = w_sb ? -w_b_n : w_b_n;
  end

  // One iteration step; the final result is formed from the step outputs so
  // resp_data is ready on the same edge that enters DONE.
  always_comb begin
    w_rem_sh    = {r_acc, r_y[XLEN-1]};
    w_diff      = w_rem_sh - {1'b0, r_x};
    w_qbit      = ~w_diff[XLEN];
    w_rem_next  = w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    w_quot_next = {r_y[XLEN-2:0], w_qbit};
    w_prod_next = r_acc + (r_y[0] ? r_x : '0);
    if (!r_is_div)     w_raw = w_prod_next;
    else if (r_is_rem) w_raw = r_sign_r ? -w_rem_next : w_rem_next;
    else               w_raw = r_sign_q ? -w_quot_next : w_quot_next;
    w_final = fit_word(w_raw, r_word);
  end

  always_comb begin
    w_state_next = r_state;
    o_stall      = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid && !i_flush) begin
          o_stall      = 1'b1;
          w_accept     = 1'b1;
          w_state_next = w_special ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        o_stall = 1'b1;
        if (r_cnt == CW'(1)) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (i_flush) w_state_next = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_acc        <= '0;
      r_is_div     <= 1'b0;
      r_is_rem     <= 1'b0;
      r_word       <= 1'b0;
      r_sign_q     <= 1'b0;
      r_sign_r     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept) begin
        r_is_div <= w_is_div;
        r_is_rem <= w_is_rem;
        r_word   <= i_req_word;
        r_sign_q <= w_sa ^ w_sb;
        r_sign_r <= w_sa;
        r_cnt    <= i_req_word ? CW'(32) : CW'(XLEN);
        r_acc    <= '0;
        if (w_is_div) begin
          r_x <= w_mag_b;
          r_y <= i_req_word ? {w_mag_a[31:0], {(XLEN-32){1'b0}}} : w_mag_a;
        end else begin
          r_x <= i_req_a;
          r_y <= i_req_b;
        end
        if (w_special) begin
          r_resp_valid <= 1'b1;
          r_resp_data  <= w_special_res;
        end
      end else if (r_state == S_BUSY && !i_flush) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_is_div) begin
          r_acc <= w_rem_next;
          r_y   <= w_quot_next;
        end else begin
          r_acc <= w_prod_next;
          r_x   <= r_x << 1;
          r_y   <= r_y >> 1;
        end
        if (r_cnt == CW'(1)) begin
          r_resp_valid <= 1'b1;
          r_resp_data  <= w_final;
        end
      end
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected result and latency are queued
// at issue and compared when resp_valid appears.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic        req_word = 1'b0;
  logic [63:0] req_a = '0, req_b = '0;
  logic        flush = 1'b0;
  logic        stall, resp_valid;
  logic [63:0] resp_data;

  typedef struct {
    logic [63:0] data;
    int          lat;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  muldiv_sequencer #(.XLEN(64)) dut (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .i_req_op(req_op),
    .i_req_word(req_word), .i_req_a(req_a), .i_req_b(req_b), .i_flush(flush),
    .o_stall(stall), .o_resp_valid(resp_valid), .o_resp_data(resp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
  endtask

  // Reference model built on native SV arithmetic.
  function automatic logic [63:0] ref_data(input logic [2:0] op, input logic word,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ua, ub, r;
    longint      sa, sb;
    logic        ovf;
    ua  = word ? {32'b0, a[31:0]} : a;
    ub  = word ? {32'b0, b[31:0]} : b;
    sa  = word ? {{32{a[31]}}, a[31:0]} : a;
    sb  = word ? {{32{b[31]}}, b[31:0]} : b;
    ovf = !word && (a == 64'h8000_0000_0000_0000) && (b == '1);
    case (op)
      3'd1: if (ub == 0) r = '1; else if (ovf) r = a; else r = sa / sb;
      3'd2: if (ub == 0) r = '1; else r = ua / ub;
      3'd3: if (ub == 0) r = sa; else if (ovf) r = '0; else r = sa % sb;
      3'd4: if (ub == 0) r = ua; else r = ua % ub;
      default: r = a * b;
    endcase
    return word ? {{32{r[31]}}, r[31:0]} : r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic word,
                                 input logic [63:0] a, input logic [63:0] b);
    logic is_div, sgn, bz, ovf;
    is_div = (op >= 3'd1) && (op <= 3'd4);
    sgn    = (op == 3'd1) || (op == 3'd3);
    bz     = word ? (b[31:0] == 0) : (b == 0);
    ovf    = word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                  : (a == 64'h8000_0000_0000_0000 && b == '1);
    if (is_div && (bz || (sgn && ovf))) return 1;
    return word ? 33 : 65;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) check("spurious_resp", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        check({e.tag, "_data"}, resp_data, e.data);
        check({e.tag, "_lat"}, 64'(cyc - e.cyc), 64'(e.lat));
      end
    end
  end

  task automatic push_exp(input logic [63:0] d, input int lat, input string tag);
    exp_t e;
    e.data = d; e.lat = lat; e.cyc = cyc; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [2:0] op, input logic word,
                       input logic [63:0] a, input logic [63:0] b);
    req_valid = 1'b1; req_op = op; req_word = word; req_a = a; req_b = b;
  endtask

  // Issue one op, count stalled cycles until the response drains.
  task automatic do_op(input logic [2:0] op, input logic word, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_d, input int exp_lat,
                       input string tag);
    int stall_cnt, guard;
    stall_cnt = 0; guard = 0;
    @(negedge clk);
    drive(op, word, a, b);
    push_exp(exp_d, exp_lat, tag);
    #1 if (stall) stall_cnt++;
    forever begin
      @(negedge clk);
      req_valid = 1'b0;
      #2;
      if (sb.size() == 0) break;
      if (stall) stall_cnt++;
      guard++;
      if (guard > 200) begin
        check({tag, "_timeout"}, 64'(guard), 64'd0);
        sb.delete();
        break;
      end
    end
    check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
    check({tag, "_stall_done"}, 64'(stall), 64'd0);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      #2;
      guard++;
      if (guard > 200) begin
        check({tag, "_timeout"}, 64'(guard), 64'd0);
        sb.delete();
      end
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic        w;
    logic [63:0] a, b;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);

    do_op(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65, "mul_3x-5");
    do_op(3'd1, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_-7_2");
    do_op(3'd3, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "rem_-7_2");
    do_op(3'd4, 1'b0, 64'd7, 64'd2, 64'd1, 65, "remu_7_2");
    do_op(3'd2, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu_by0");
    do_op(3'd3, 1'b0, 64'd5, 64'd0, 64'd5, 1, "rem_by0");
    do_op(3'd1, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, "div_ovf");
    do_op(3'd3, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, "rem_ovf");
    do_op(3'd1, 1'b1, 64'h1_0000_0010, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF0, 33, "divw");
    do_op(3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw");
    do_op(3'd1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf");
    do_op(3'd7, 1'b0, 64'd6, 64'd7, 64'd42, 65, "op7_as_mul");

    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      if (i % 5 == 4)      b = '0;
      else if (i % 3 == 0) b = 64'($urandom_range(1, 1000)) * ((i % 2 == 0) ? 64'd1 : '1);
      else                 b = {$urandom, $urandom};
      do_op(op, w, a, b, ref_data(op, w, a, b), ref_lat(op, w, a, b), $sformatf("rand%0d", i));
    end

    // flush overrides a request in IDLE
    @(negedge clk);
    drive(3'd2, 1'b0, 64'd100, 64'd7);
    flush = 1'b1;
    #1 check("flush_idle_stall", 64'(stall), 64'd0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1 check("flush_idle_not_busy", 64'(stall), 64'd0);

    // flush at BUSY cycle 10, then immediate DIVU 100/7
    @(negedge clk);
    drive(3'd2, 1'b0, 64'd1000, 64'd3);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy_stall", 64'(stall), 64'd0);
    check("flush_busy_resp", 64'(resp_valid), 64'd0);
    do_op(3'd2, 1'b0, 64'd100, 64'd7, 64'd14, 65, "divu_after_flush");

    // back-to-back with req_valid held through DONE
    @(negedge clk);
    drive(3'd0, 1'b0, 64'd123456789, 64'd1000);
    push_exp(64'd123456789000, 65, "b2b_mul");
    drain("b2b_mul");
    drive(3'd1, 1'b0, -64'sd1000, 64'd7);
    check("b2b_done_stall", 64'(stall), 64'd0);
    @(negedge clk);
    push_exp(ref_data(3'd1, 1'b0, -64'sd1000, 64'd7), 65, "b2b_div");
    #1;
    check("b2b_idle_stall", 64'(stall), 64'd1);
    check("b2b_idle_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    drain("b2b_div");

    // reset mid-BUSY
    @(negedge clk);
    drive(3'd0, 1'b0, 64'd9, 64'd9);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check("midrst_resp_data", resp_data, 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
